srl_tap_delay: RTL and testbench
================================

# srl_tap_delay

Parametrised, shift-register-inferable delay line with an enable, a runtime-selectable tap, a registered output and fill tracking. Storage stays free of reset so synthesis maps it onto SRL primitives; only the control and output registers are reset. It generalises the fixed-length, full-depth delay line: configurable width, depth and clock polarity, a dynamic read point, and a qualified output. It is the next architecture test block for SRL inference with variable-address taps and a trailing flip-flop.

## Interface
- WIDTH, 8: data width in bits, 1 or more.
- DEPTH, 32: number of storage stages, 1 or more; need not be a power of 2.
- CLKPOL, 1: active clock edge; 1 = rising, 0 = falling. Applies to all sequential logic, including reset.
- TAPW, derived as max(1, clog2(DEPTH)): width of `tap`.
- FILLW, derived as clog2(DEPTH+1): width of `fill`.

- clk  input  1  clock; single clock domain.
- resetn  input  1  reset, synchronous, active-low.
- e  input  1  shift enable.
- i  input  WIDTH  shift-in data.
- tap  input  TAPW  read stage index; 0 is the newest stage.
- q  output  WIDTH  registered value of stage[tap].
- q_valid  output  1  q holds data written since the last reset.
- fill  output  FILLW  number of shifts since reset, saturating at DEPTH.

## Operation
- Storage is stage[0..DEPTH-1], each WIDTH bits.
  - Initial value: bit w of stage[d] = 1 when (d+w) is even, 0 otherwise.
  - Storage is never reset.
- Shift, on the active edge with e=1:
  - stage[0] <= i.
  - stage[k] <= stage[k-1] for k from 1 to DEPTH-1.
  - The shift happens regardless of resetn, so reset logic never enters the SRL.
  - With e=0, all stages hold.
- Tap selection:
  - The effective tap is tap_eff = min(tap, DEPTH-1).
  - Out-of-range taps clamp to DEPTH-1. They never wrap and never produce X.
- Output register, on every active edge while resetn=1:
  - q <= stage[tap_eff], using pre-edge contents.
  - q_valid <= (fill > tap_eff), using pre-edge fill.
  - q updates whether or not e is high.
- Fill counter: while resetn=1, fill increments by 1 on each edge with e=1 and saturates at DEPTH.
- Reset (resetn=0 at an active edge):
  - q <= 0, q_valid <= 0, fill <= 0.
  - If e=1 on that same edge, storage still shifts. fill stays 0 because reset wins.
- Power-up without reset: q, q_valid and fill start at 0.

## Timing
- Latency: a sample presented with e=1 at edge N appears on q after edge N+tap_eff+1, provided e=1 on every edge in between.
- First-valid point: q_valid first rises after the edge following the (tap_eff+1)-th shift since reset.
- Stall: while e=0, both q and q_valid are stable. The exception is a tap change, which is observed one edge later.
- Tap change: the new tap is sampled at the next active edge; q and q_valid reflect it after that edge. There are no glitches and no extra cycles.
- Simultaneous e=1 and a tap change on one edge: q takes the pre-shift stage[new tap_eff].
- Reset mid-stream: after the reset edge, q=0, q_valid=0 and fill=0. Valid returns only after tap_eff+1 further shifts, even though the old data is still physically present.
- The fill saturation boundary is DEPTH; fill=DEPTH holds under continued shifting.
- CLKPOL=0: identical behaviour referenced to falling edges.

## Test plan
- Init pattern (WIDTH=8, DEPTH=32): no reset, e=0, tap=3, run one edge -> q=8'hAA (bit w set when 3+w is even), q_valid=0.
- Streaming (tap=3): release reset, e=1, i=1,2,3,... on successive edges -> q_valid rises after the 5th edge with q=1, then q=2,3,... each edge; fill saturates at 32.
- Stall and tap change: with the pipeline full, drop e for 4 edges -> q constant. Set tap=0 with e=0 -> q equals the newest sample after 1 edge.
- Clamp (DEPTH=20, TAPW=5): fill the line, set tap=31 -> q equals stage[19], the sample shifted in 20 shifts earlier; q_valid=1.
- Reset mid-stream with e=1 (tap=2): after the reset edge, q=0, q_valid=0, fill=0. q_valid returns after exactly 3 further shifts plus 1 edge.
- CLKPOL=0: repeat the streaming test -> identical sequence, with all updates on falling edges.

Source files
------------

// File: rtl/srl_tap_delay.sv
`default_nettype none
// ------------------------------------------------------------------------
// srl_tap_delay : reset-free shift storage with a clamped runtime tap,
//                 registered output, valid flag and saturating fill count.
// Revision      : 1.0
// ------------------------------------------------------------------------
module srl_tap_delay #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter bit CLKPOL = 1'b1,
  parameter int TAPW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int FILLW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             e,
  input  logic [WIDTH-1:0] i,
  input  logic [TAPW-1:0]  tap,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [FILLW-1:0] fill
);

  typedef logic [WIDTH-1:0] stage_arr_t [DEPTH];

  localparam logic [TAPW-1:0]  c_tap_max  = TAPW'(DEPTH - 1);
  localparam logic [FILLW-1:0] c_fill_max = FILLW'(DEPTH);

  function automatic stage_arr_t init_stages();
    stage_arr_t s;
    for (int d = 0; d < DEPTH; d++) begin
      for (int w = 0; w < WIDTH; w++) begin
        s[d][w] = ((d + w) % 2 == 0);
      end
    end
    return s;
  endfunction

  // Power-up contents only; the storage itself never sees a reset.
  stage_arr_t       r_stage   = init_stages();
  logic [WIDTH-1:0] r_q       = '0;
  logic             r_q_valid = 1'b0;
  logic [FILLW-1:0] r_fill    = '0;

  logic [TAPW-1:0]  w_tap_eff;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_q_valid_nxt;
  logic [FILLW-1:0] w_fill_nxt;

  always_comb begin
    w_tap_eff     = (tap > c_tap_max) ? c_tap_max : tap;
    w_q_nxt       = r_stage[w_tap_eff];
    w_q_valid_nxt = 32'(r_fill) > 32'(w_tap_eff);
    w_fill_nxt    = r_fill;
    if (e && (r_fill != c_fill_max)) begin
      w_fill_nxt = r_fill + FILLW'(1);
    end
  end

  if (CLKPOL) begin : g_rise
    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_q       <= '0;
        r_q_valid <= 1'b0;
        r_fill    <= '0;
      end else begin
        r_q       <= w_q_nxt;
        r_q_valid <= w_q_valid_nxt;
        r_fill    <= w_fill_nxt;
      end
    end

    always_ff @(posedge clk) begin
      if (e) begin
        r_stage[0] <= i;
        for (int k = 1; k < DEPTH; k++) begin
          r_stage[k] <= r_stage[k-1];
        end
      end
    end
  end else begin : g_fall
    always_ff @(negedge clk) begin
      if (!resetn) begin
        r_q       <= '0;
        r_q_valid <= 1'b0;
        r_fill    <= '0;
      end else begin
        r_q       <= w_q_nxt;
        r_q_valid <= w_q_valid_nxt;
        r_fill    <= w_fill_nxt;
      end
    end

    always_ff @(negedge clk) begin
      if (e) begin
        r_stage[0] <= i;
        for (int k = 1; k < DEPTH; k++) begin
          r_stage[k] <= r_stage[k-1];
        end
      end
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign fill    = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_srl_tap_delay.sv
`default_nettype none
// tb_srl_tap_delay: one stimulus stream feeds a rising-edge DEPTH=32 line and a
// falling-edge DEPTH=20 line; per-edge expectations are queued and popped by monitors.
module tb_srl_tap_delay;

  logic       clk    = 1'b1;
  logic       resetn = 1'b1;
  logic       e      = 1'b0;
  logic [7:0] i      = '0;
  logic [4:0] tap    = 5'd3;

  logic [7:0] q_a, q_b;
  logic       v_a, v_b;
  logic [5:0] fill_a;
  logic [4:0] fill_b;

  always #5 clk = ~clk;

  srl_tap_delay #(.WIDTH(8), .DEPTH(32), .CLKPOL(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .e(e), .i(i), .tap(tap),
    .q(q_a), .q_valid(v_a), .fill(fill_a)
  );

  srl_tap_delay #(.WIDTH(8), .DEPTH(20), .CLKPOL(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .e(e), .i(i), .tap(tap),
    .q(q_b), .q_valid(v_b), .fill(fill_b)
  );

  typedef struct {
    string name;
    int    q;     // -1: not checked
    int    v;
    int    fill;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string dut, input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s %s: got %0d expected %0d", dut, name, act, exp);
  endtask

  // Inputs change at posedge+2, so dut_b consumes them at the following
  // negedge and dut_a at the posedge after that.
  task automatic step(input logic rn, input logic en, input int din, input int t,
                      input string name,
                      input int eq_a, input int ev_a, input int ef_a,
                      input int eq_b, input int ev_b, input int ef_b);
    exp_t xa;
    exp_t xb;
    resetn = rn;
    e      = en;
    i      = 8'(din);
    tap    = 5'(t);
    xa.name = name; xa.q = eq_a; xa.v = ev_a; xa.fill = ef_a;
    xb.name = name; xb.q = eq_b; xb.v = ev_b; xb.fill = ef_b;
    qa.push_back(xa);
    qb.push_back(xb);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (qa.size() > 0) begin
      x = qa.pop_front();
      if (x.q >= 0) check("A", {x.name, " q"}, int'(q_a), x.q);
      check("A", {x.name, " q_valid"}, int'(v_a), x.v);
      check("A", {x.name, " fill"}, int'(fill_a), x.fill);
    end
  end

  always @(negedge clk) begin
    exp_t x;
    #1;
    if (qb.size() > 0) begin
      x = qb.pop_front();
      if (x.q >= 0) check("B", {x.name, " q"}, int'(q_b), x.q);
      check("B", {x.name, " q_valid"}, int'(v_b), x.v);
      check("B", {x.name, " fill"}, int'(fill_b), x.fill);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-up pattern at stage 3 is 8'hAA in both lines.
    step(1, 0, 0, 3, "init", 170, 0, 0, 170, 0, 0);
    step(0, 0, 0, 3, "reset", 0, 0, 0, 0, 0, 0);

    for (int k = 1; k <= 40; k++) begin
      step(1, 1, k, 3, "stream",
           (k >= 5) ? k - 4 : -1, (k >= 5) ? 1 : 0, (k < 32) ? k : 32,
           (k >= 5) ? k - 4 : -1, (k >= 5) ? 1 : 0, (k < 20) ? k : 20);
    end

    // stage[d] now holds sample 40-d
    for (int s = 0; s < 4; s++) begin
      step(1, 0, 255, 3, "stall", 37, 1, 32, 37, 1, 20);
    end
    step(1, 0, 255, 0,  "tap0",  40, 1, 32, 40, 1, 20);
    step(1, 0, 255, 31, "tap31",  9, 1, 32, 21, 1, 20);
    step(1, 0, 255, 19, "tap19", 21, 1, 32, 21, 1, 20);
    step(1, 0, 255, 20, "tap20", 20, 1, 32, 21, 1, 20);

    // Reset edge still shifts 100 in: stage = 100,40,39,...
    step(0, 1, 100, 2, "rst_e", 0, 0, 0, 0, 0, 0);
    step(1, 1, 101, 2, "post1",  39, 0, 1,  39, 0, 1);
    step(1, 1, 102, 2, "post2",  40, 0, 2,  40, 0, 2);
    step(1, 1, 103, 2, "post3", 100, 0, 3, 100, 0, 3);
    step(1, 1, 104, 2, "post4", 101, 1, 4, 101, 1, 4);
    step(1, 1, 105, 0, "tap_shift", 104, 1, 5, 104, 1, 5);
    step(1, 0, 0,   0, "hold",      105, 1, 5, 105, 1, 5);

    @(posedge clk);
    #3;
    n_checks++;
    if (qa.size() == 0 && qb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
